// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command codes, ALU operand
// register addresses and the frame decoder state encoding.
package sys_ctrl_pkg;

   // First byte of each frame selects the command
   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   // Register-file locations that feed the ALU operands
   localparam logic [7:0] REG_A = 8'h00;
   localparam logic [7:0] REG_B = 8'h01;

   // Frame decoder states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_ALU_A,
      ST_ALU_B,
      ST_ALU_FUN,
      ST_ALU_WAIT,
      ST_PUSH_LO,
      ST_PUSH_HI,
      ST_PUSH_RD
   } state_t;

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Bus bundle between the command frame decoder and its neighbours: the
// synchronized UART byte stream, the register file, the ALU and the TX FIFO.
// The master modport is the decoder's view; slave is the surrounding system.
interface cmd_frame_decoder_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   // Received byte stream
   logic [DATA_WIDTH-1:0]   RX_P_DATA;
   logic                    RX_D_VLD;
   // Register file
   logic                    WrEn;
   logic                    RdEn;
   logic [ADDR_WIDTH-1:0]   Address;
   logic [DATA_WIDTH-1:0]   WrData;
   logic [DATA_WIDTH-1:0]   RdData;
   logic                    RdData_Valid;
   // ALU
   logic                    ALU_EN;
   logic [3:0]              ALU_FUN;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    OUT_VALID;
   logic                    CLK_EN;
   // Response FIFO toward UART TX
   logic                    WR_INC;
   logic [DATA_WIDTH-1:0]   WR_DATA;
   logic                    FULL;

   modport master (
      input  RX_P_DATA, RX_D_VLD,
      output WrEn, RdEn, Address, WrData,
      input  RdData, RdData_Valid,
      output ALU_EN, ALU_FUN, CLK_EN,
      input  ALU_OUT, OUT_VALID,
      output WR_INC, WR_DATA,
      input  FULL
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD,
      input  WrEn, RdEn, Address, WrData,
      output RdData, RdData_Valid,
      input  ALU_EN, ALU_FUN, CLK_EN,
      output ALU_OUT, OUT_VALID,
      input  WR_INC, WR_DATA,
      output FULL
   );

endinterface

// File: rtl/cmd_frame_decoder.sv
// Byte-level command frame decoder. Turns UART command frames into register
// file writes/reads and ALU operations, and pushes response bytes (read data
// or the 16-bit ALU result, LSB first) into the TX FIFO. Every output is a
// register; the push group holds its byte on WR_DATA until FULL allows it.
module cmd_frame_decoder
   import sys_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
)(
   input  logic                CLK,
   input  logic                RST,
   cmd_frame_decoder_if.master io_bus
);

   state_t                  r_state;
   state_t                  w_state_next;

   // Registered outputs and their next values
   logic                    r_wr_en,     w_wr_en_next;
   logic                    r_rd_en,     w_rd_en_next;
   logic [ADDR_WIDTH-1:0]   r_address,   w_address_next;
   logic [DATA_WIDTH-1:0]   r_wr_data,   w_wr_data_next;
   logic                    r_alu_en,    w_alu_en_next;
   logic [3:0]              r_alu_fun,   w_alu_fun_next;
   logic                    r_clk_en,    w_clk_en_next;
   logic                    r_wr_inc,    w_wr_inc_next;
   logic [DATA_WIDTH-1:0]   r_fifo_data, w_fifo_data_next;

   // Frame-internal storage: write address and ALU result high byte
   logic [ADDR_WIDTH-1:0]   r_addr_hold, w_addr_hold_next;
   logic [DATA_WIDTH-1:0]   r_alu_hi,    w_alu_hi_next;

   logic                    w_rx_vld;
   logic [DATA_WIDTH-1:0]   w_rx_byte;

   assign w_rx_vld  = io_bus.RX_D_VLD;
   assign w_rx_byte = io_bus.RX_P_DATA;

   assign io_bus.WrEn    = r_wr_en;
   assign io_bus.RdEn    = r_rd_en;
   assign io_bus.Address = r_address;
   assign io_bus.WrData  = r_wr_data;
   assign io_bus.ALU_EN  = r_alu_en;
   assign io_bus.ALU_FUN = r_alu_fun;
   assign io_bus.CLK_EN  = r_clk_en;
   assign io_bus.WR_INC  = r_wr_inc;
   assign io_bus.WR_DATA = r_fifo_data;

   // State register plus the registered outputs; reset aborts any frame
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_address   <= '0;
         r_wr_data   <= '0;
         r_alu_en    <= 1'b0;
         r_alu_fun   <= '0;
         r_clk_en    <= 1'b0;
         r_wr_inc    <= 1'b0;
         r_fifo_data <= '0;
         r_addr_hold <= '0;
         r_alu_hi    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_wr_en     <= w_wr_en_next;
         r_rd_en     <= w_rd_en_next;
         r_address   <= w_address_next;
         r_wr_data   <= w_wr_data_next;
         r_alu_en    <= w_alu_en_next;
         r_alu_fun   <= w_alu_fun_next;
         r_clk_en    <= w_clk_en_next;
         r_wr_inc    <= w_wr_inc_next;
         r_fifo_data <= w_fifo_data_next;
         r_addr_hold <= w_addr_hold_next;
         r_alu_hi    <= w_alu_hi_next;
      end
   end

   // Next-state: byte-driven frame walk, then the wait and push groups.
   // In a push state r_wr_inc high means the byte on WR_DATA went out this
   // cycle, so the push group advances.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_rx_vld) begin
               case (w_rx_byte)
                  CMD_WR:      w_state_next = ST_WR_ADDR;
                  CMD_RD:      w_state_next = ST_RD_ADDR;
                  CMD_ALU_OP:  w_state_next = ST_ALU_A;
                  CMD_ALU_NOP: w_state_next = ST_ALU_FUN;
                  default:     w_state_next = ST_IDLE;
               endcase
            end
         end
         ST_WR_ADDR:  if (w_rx_vld) w_state_next = ST_WR_DATA;
         ST_WR_DATA:  if (w_rx_vld) w_state_next = ST_IDLE;
         ST_RD_ADDR:  if (w_rx_vld) w_state_next = ST_RD_WAIT;
         ST_RD_WAIT:  if (io_bus.RdData_Valid) w_state_next = ST_PUSH_RD;
         ST_ALU_A:    if (w_rx_vld) w_state_next = ST_ALU_B;
         ST_ALU_B:    if (w_rx_vld) w_state_next = ST_ALU_FUN;
         ST_ALU_FUN:  if (w_rx_vld) w_state_next = ST_ALU_WAIT;
         ST_ALU_WAIT: if (io_bus.OUT_VALID) w_state_next = ST_PUSH_LO;
         ST_PUSH_LO:  if (r_wr_inc) w_state_next = ST_PUSH_HI;
         ST_PUSH_HI:  if (r_wr_inc) w_state_next = ST_IDLE;
         ST_PUSH_RD:  if (r_wr_inc) w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   // Output logic: strobes default low, data buses hold their last values.
   // A pending push is offered whenever FULL is low; the byte stays stable.
   always_comb begin
      w_wr_en_next     = 1'b0;
      w_rd_en_next     = 1'b0;
      w_alu_en_next    = 1'b0;
      w_clk_en_next    = 1'b0;
      w_wr_inc_next    = 1'b0;
      w_address_next   = r_address;
      w_wr_data_next   = r_wr_data;
      w_alu_fun_next   = r_alu_fun;
      w_fifo_data_next = r_fifo_data;
      w_addr_hold_next = r_addr_hold;
      w_alu_hi_next    = r_alu_hi;
      case (r_state)
         ST_WR_ADDR: begin
            if (w_rx_vld) w_addr_hold_next = w_rx_byte[ADDR_WIDTH-1:0];
         end
         ST_WR_DATA: begin
            if (w_rx_vld) begin
               w_wr_en_next   = 1'b1;
               w_address_next = r_addr_hold;
               w_wr_data_next = w_rx_byte;
            end
         end
         ST_RD_ADDR: begin
            if (w_rx_vld) begin
               w_rd_en_next   = 1'b1;
               w_address_next = w_rx_byte[ADDR_WIDTH-1:0];
            end
         end
         ST_RD_WAIT: begin
            if (io_bus.RdData_Valid) begin
               w_fifo_data_next = io_bus.RdData;
               w_wr_inc_next    = ~io_bus.FULL;
            end
         end
         ST_ALU_A: begin
            if (w_rx_vld) begin
               w_wr_en_next   = 1'b1;
               w_address_next = REG_A[ADDR_WIDTH-1:0];
               w_wr_data_next = w_rx_byte;
            end
         end
         ST_ALU_B: begin
            if (w_rx_vld) begin
               w_wr_en_next   = 1'b1;
               w_address_next = REG_B[ADDR_WIDTH-1:0];
               w_wr_data_next = w_rx_byte;
            end
         end
         ST_ALU_FUN: begin
            if (w_rx_vld) begin
               w_alu_fun_next = w_rx_byte[3:0];
               w_alu_en_next  = 1'b1;
               w_clk_en_next  = 1'b1;
            end
         end
         ST_ALU_WAIT: begin
            // Gate stays open until the result arrives, closes the cycle after
            w_clk_en_next = ~io_bus.OUT_VALID;
            if (io_bus.OUT_VALID) begin
               w_alu_hi_next    = io_bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
               w_fifo_data_next = io_bus.ALU_OUT[DATA_WIDTH-1:0];
               w_wr_inc_next    = ~io_bus.FULL;
            end
         end
         ST_PUSH_LO: begin
            // Once the low byte is out, present the high byte immediately
            if (r_wr_inc) w_fifo_data_next = r_alu_hi;
            w_wr_inc_next = ~io_bus.FULL;
         end
         ST_PUSH_HI, ST_PUSH_RD: begin
            if (!r_wr_inc) w_wr_inc_next = ~io_bus.FULL;
         end
         default: begin
         end
      endcase
   end

endmodule
